// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the
// encode and decode immediate paths.
package imm_encoder_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_op_e;

   // Highest immediate bit that may differ from the sign
   localparam int I_MSB = 11;
   localparam int S_MSB = 11;
   localparam int B_MSB = 12;
   localparam int J_MSB = 20;
   // Lowest immediate bit carried by the U format
   localparam int U_LSB = 12;

   // True when v[31:msb] are all equal
   function automatic logic sext_ok(
      input logic [31:0] v,
      input int          msb
   );
      logic [31:0] m;
      m = 32'hFFFF_FFFF << msb;
      return ((v & m) == m) || ((v & m) == 32'h0);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational range check and field packing
// of an immediate into a base instruction word.
module imm_pack
   import imm_encoder_pkg::*;
(
   input  logic [31:0] base_i,
   input  logic [31:0] imm_i,
   input  logic [2:0]  op_i,
   output logic [31:0] inst_o,
   output logic        err_o
);

   logic [31:0] pk;
   logic        ok;

   // Pack per format; unrepresentable keeps the base
   always_comb begin
      pk = base_i;
      ok = 1'b0;
      case (op_i)
         IMM_I: begin
            ok         = sext_ok(imm_i, I_MSB);
            pk[31:20]  = imm_i[11:0];
         end
         IMM_S: begin
            ok         = sext_ok(imm_i, S_MSB);
            pk[31:25]  = imm_i[11:5];
            pk[11:7]   = imm_i[4:0];
         end
         IMM_B: begin
            ok         = sext_ok(imm_i, B_MSB) && !imm_i[0];
            pk[31]     = imm_i[12];
            pk[30:25]  = imm_i[10:5];
            pk[11:8]   = imm_i[4:1];
            pk[7]      = imm_i[11];
         end
         IMM_J: begin
            ok         = sext_ok(imm_i, J_MSB) && !imm_i[0];
            pk[31]     = imm_i[20];
            pk[30:21]  = imm_i[10:1];
            pk[20]     = imm_i[11];
            pk[19:12]  = imm_i[19:12];
         end
         IMM_U: begin
            ok         = (imm_i[U_LSB-1:0] == '0);
            pk[31:12]  = imm_i[31:12];
         end
         default: begin
            ok = 1'b0;
         end
      endcase
      inst_o = ok ? pk : base_i;
      err_o  = !ok;
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with
// a saturating count of errored results.
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_base,
   input  logic [31:0]          in_imm,
   input  logic [2:0]           in_imm_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_clr
);

   logic [31:0]          pk_inst;
   logic                 pk_err;
   logic                 s1_v_q;
   logic [31:0]          s1_inst_q;
   logic                 s1_err_q;
   logic                 s2_v_q;
   logic [31:0]          s2_inst_q;
   logic                 s2_err_q;
   logic [ERR_CNT_W-1:0] cnt_q;
   logic [ERR_CNT_W-1:0] cnt_d;
   logic                 s1_adv;
   logic                 s2_adv;

   imm_pack u_pack (
      .base_i (in_base),
      .imm_i  (in_imm),
      .op_i   (in_imm_op),
      .inst_o (pk_inst),
      .err_o  (pk_err)
   );

   assign s2_adv    = !s2_v_q || out_ready;
   assign s1_adv    = !s1_v_q || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_v_q;
   assign out_inst  = s2_inst_q;
   assign out_err   = s2_err_q;
   assign err_cnt   = cnt_q;

   // Next error count; clear beats a same-cycle increment
   always_comb begin
      cnt_d = cnt_q;
      if (err_clr) begin
         cnt_d = '0;
      end else if (s2_v_q && out_ready && s2_err_q
                   && (cnt_q != '1)) begin
         cnt_d = cnt_q + ERR_CNT_W'(1);
      end
   end

   // Pipeline stages and counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_inst_q <= '0;
         s1_err_q  <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_inst_q <= '0;
         s2_err_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (s1_adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
               s1_inst_q <= pk_inst;
               s1_err_q  <= pk_err;
            end
         end
         if (s2_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
               s2_inst_q <= s1_inst_q;
               s2_err_q  <= s1_err_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised bench for imm_encoder against a
// table-driven reference model and scoreboard.
module tb_imm_encoder;

   localparam int CW  = 3;
   localparam int MAX = (1 << CW) - 1;

   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic [31:0] imm;
      logic [2:0]  op;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_base;
   logic [31:0]   in_imm;
   logic [2:0]    in_imm_op;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_inst;
   logic          out_err;
   logic [CW-1:0] err_cnt;
   logic          err_clr;

   int   checks = 0;
   int   errors = 0;
   int   mode   = 0;
   int   m_cnt  = 0;
   ent_t q[$];

   logic        held_v = 1'b0;
   logic [31:0] h_inst;
   logic        h_err;

   imm_encoder #(.ERR_CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_base   (in_base),
      .in_imm    (in_imm),
      .in_imm_op (in_imm_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .err_cnt   (err_cnt),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Source immediate bit for instruction bit d, -1 = base
   function automatic int src(input int op, input int d);
      case (op)
         0: return (d >= 20) ? d - 20 : -1;
         1: begin
            if (d >= 25) return d - 20;
            if (d >= 7 && d <= 11) return d - 7;
            return -1;
         end
         2: begin
            if (d == 31) return 12;
            if (d >= 25) return d - 20;
            if (d >= 8 && d <= 11) return d - 7;
            if (d == 7) return 11;
            return -1;
         end
         3: begin
            if (d == 31) return 20;
            if (d >= 21) return d - 20;
            if (d == 20) return 11;
            if (d >= 12) return d;
            return -1;
         end
         4: return (d >= 12) ? d : -1;
         default: return -1;
      endcase
   endfunction

   function automatic ent_t model(
      input logic [31:0] b,
      input logic [31:0] imm,
      input logic [2:0]  op
   );
      ent_t   e;
      longint v;
      bit     ok;
      int     s;
      v = longint'($signed(imm));
      case (op)
         3'd0, 3'd1: ok = (v >= -2048) && (v <= 2047);
         3'd2: ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
         3'd3: ok = (v >= -(64'sd1 << 20)) && (v < (64'sd1 << 20))
                    && (v % 2 == 0);
         3'd4: ok = (imm % 4096 == 0);
         default: ok = 1'b0;
      endcase
      e.inst = b;
      if (ok) begin
         for (int d = 0; d < 32; d++) begin
            s = src(int'(op), d);
            if (s >= 0) e.inst[d] = imm[s];
         end
      end
      e.err = !ok;
      e.imm = imm;
      e.op  = op;
      return e;
   endfunction

   // Decode-side sign extender
   function automatic logic [31:0] dec(
      input logic [31:0] i,
      input logic [2:0]  op
   );
      case (op)
         3'd0: return {{20{i[31]}}, i[31:20]};
         3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25],
                       i[11:8], 1'b0};
         3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20],
                       i[30:21], 1'b0};
         3'd4: return {i[31:12], 12'h000};
         default: return 32'h0;
      endcase
   endfunction

   // out_ready / err_clr pattern generator
   always @(posedge clk) begin
      #2;
      case (mode)
         0: begin out_ready = 1'b1; err_clr = 1'b0; end
         1: begin
            out_ready = ($urandom % 4) != 0;
            err_clr   = ($urandom % 64) == 0;
         end
         2: begin out_ready = 1'b0; err_clr = 1'b0; end
         default: ;
      endcase
   end

   // Output monitor: scoreboard, hold and counter checks
   always @(negedge clk) begin
      ent_t e;
      logic xe;
      if (rst) begin
         q.delete();
         m_cnt  = 0;
         held_v = 1'b0;
      end else begin
         xe = 1'b0;
         if (held_v) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_inst", 64'(out_inst), 64'(h_inst));
            chk("hold_err", 64'(out_err), 64'(h_err));
         end
         if (out_valid && out_ready) begin
            chk("cnt", 64'(err_cnt), 64'(m_cnt));
            if (q.size() == 0) begin
               chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               e  = q.pop_front();
               xe = e.err;
               chk("inst", 64'(out_inst), 64'(e.inst));
               chk("err", 64'(out_err), 64'(e.err));
               if (!e.err)
                  chk("roundtrip", 64'(dec(out_inst, e.op)),
                      64'(e.imm));
            end
         end
         if (err_clr) m_cnt = 0;
         else if (xe && m_cnt != MAX) m_cnt++;
         held_v = out_valid && !out_ready;
         h_inst = out_inst;
         h_err  = out_err;
      end
   end

   task automatic send(
      input logic [31:0] b,
      input logic [31:0] imm,
      input logic [2:0]  op,
      input logic [31:0] ei,
      input logic        ee
   );
      int   n = 0;
      bit   done = 0;
      logic rdy;
      ent_t e;
      in_valid  = 1'b1;
      in_base   = b;
      in_imm    = imm;
      in_imm_op = op;
      while (!done) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin
            e.inst = ei;
            e.err  = ee;
            e.imm  = imm;
            e.op   = op;
            q.push_back(e);
            done = 1;
         end else if (++n > 500) begin
            chk("send_timeout", 64'(n), 64'd0);
            done = 1;
         end
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(
      input logic [31:0] b,
      input logic [31:0] imm,
      input logic [2:0]  op
   );
      ent_t e;
      e = model(b, imm, op);
      send(b, imm, op, e.inst, e.err);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 64'(q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_imm();
      logic [31:0] r;
      r = $urandom;
      case ($urandom % 5)
         0: return r;
         1: return 32'($urandom_range(0, 8191)) - 32'd4096;
         2: return 32'($urandom_range(0, 32'h3F_FFFF))
                   - 32'h20_0000;
         3: return r & 32'hFFFF_F000;
         default: return 32'($urandom_range(0, 4095)) - 32'd2048;
      endcase
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_base   = '0;
      in_imm    = '0;
      in_imm_op = '0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_inst", 64'(out_inst), 64'd0);
      chk("rst_err", 64'(out_err), 64'd0);
      chk("rst_cnt", 64'(err_cnt), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      send(32'h13, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0013, 1'b0);
      send(32'h2023, 32'd8, 3'b001, 32'h0000_2423, 1'b0);
      send(32'h63, 32'hFFFF_FFFC, 3'b010, 32'hFE00_0EE3, 1'b0);
      send(32'h6F, 32'd2048, 3'b011, 32'h0010_006F, 1'b0);
      send(32'h37, 32'h1234_5000, 3'b100, 32'h1234_5037, 1'b0);
      send(32'h63, 32'd3, 3'b010, 32'h0000_0063, 1'b1);
      send(32'h13, 32'd2048, 3'b000, 32'h0000_0013, 1'b1);
      send(32'h1234_5678, 32'd4, 3'b111, 32'h1234_5678, 1'b1);
      drain();
      @(negedge clk);
      chk("errcnt3", 64'(err_cnt), 64'd3);

      @(posedge clk);
      #1;
      mode      = 3;
      out_ready = 1'b0;
      send(32'h63, 32'd5, 3'b010, 32'h0000_0063, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("clr_pre_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      err_clr   = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      @(negedge clk);
      chk("clr_prio", 64'(err_cnt), 64'd0);
      @(posedge clk);
      #1;

      mode = 2;
      send_m($urandom, rnd_imm(), 3'($urandom % 5));
      send_m($urandom, rnd_imm(), 3'($urandom % 5));
      @(negedge clk);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_valid", 64'(out_valid), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      mode = 1;
      for (int i = 0; i < 6; i++)
         send_m($urandom, rnd_imm(), 3'($urandom % 8));
      drain();

      mode = 0;
      send(32'h13, 32'd4096, 3'b000, 32'h0000_0013, 1'b1);
      drain();
      mode = 2;
      send_m($urandom, rnd_imm(), 3'($urandom % 8));
      send_m($urandom, rnd_imm(), 3'($urandom % 8));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      mode = 1;
      repeat (20) @(posedge clk);
      #1;

      for (int i = 0; i < 10000; i++)
         send_m($urandom, rnd_imm(), 3'($urandom % 8));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
